// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Bundles the word-stream handshake and the byte-wide instruction
//            memory write port that the instruction memory loader sits between.
// Ports    : in_valid/in_data/in_ready - 32-bit instruction word stream
//            mem_we/mem_addr/mem_wdata - byte write port into instruction memory
// Modports : master - the environment (word source + memory write port)
//            slave  - the loader
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Writer side of the instruction memory. Accepts 32-bit words over
//            a valid/ready stream and writes each as four big-endian bytes
//            (MSB at the lowest address) into the byte-wide memory, holding
//            the CPU in reset while a load is in progress.
// Ports    : CLK        - clock, rising edge
//            RESET      - asynchronous, active-high reset
//            start      - one-cycle pulse, begins a load (IDLE only)
//            base_addr  - first byte address, bits [1:0] forced to zero
//            word_count - number of words to load
//            bus        - word stream in, byte write port out (slave modport)
//            busy       - load in progress
//            cpu_hold   - copy of busy, holds PC/fetch
//            done       - one-cycle pulse at the end of a successful load
//            error      - sticky address-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 8
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  input  wire logic              start,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [CNT_W-1:0]  word_count,
  imem_loader_if.slave           bus,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WR0    = 3'd2,
    S_WR1    = 3'd3,
    S_WR2    = 3'd4,
    S_WR3    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // The pointer carries one extra bit so that running off the end of memory
  // is detected rather than wrapping back to address 0.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_ptr;
  logic [CNT_W-1:0]  r_rem;
  logic [31:0]       r_wbuf;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_next_is_wr;
  logic              w_unused_base_lo;

  // Word alignment discards the two low address bits.
  assign w_unused_base_lo = ^base_addr[1:0];

  assign w_accept     = w_in_ready & bus.in_valid;
  assign w_next_is_wr = (w_next == S_WR0) || (w_next == S_WR1) ||
                        (w_next == S_WR2) || (w_next == S_WR3);

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (word_count != '0) ? S_ACCEPT : S_DONE;
        end
      end
      S_ACCEPT: begin
        // Never offer ready once the pointer is past the end: the word that
        // would overflow must stay with the source.
        if (r_ptr >= MEM_LIMIT) begin
          w_next = S_ERR;
        end else begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_next = S_WR0;
          end
        end
      end
      S_WR0:   w_next = S_WR1;
      S_WR1:   w_next = S_WR2;
      S_WR2:   w_next = S_WR3;
      S_WR3:   w_next = (r_rem == REM_ONE) ? S_DONE : S_ACCEPT;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_wbuf   <= '0;
      r_mem_we <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Status and write-enable are registered from the next state so they
      // line up exactly with the state they describe, glitch-free.
      r_mem_we <= w_next_is_wr;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      if (w_next == S_ERR) begin
        r_error <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            if (word_count != '0) begin
              r_ptr <= {1'b0, base_addr[ADDR_W-1:2], 2'b00};
              r_rem <= word_count;
            end
          end
        end
        S_ACCEPT: begin
          if (w_accept) begin
            r_wbuf <= bus.in_data;
          end
        end
        // The write data is always the top byte of the buffer, so shifting
        // left after each byte emits the word most-significant byte first.
        S_WR0, S_WR1, S_WR2: begin
          r_ptr  <= r_ptr + PTR_ONE;
          r_wbuf <= {r_wbuf[23:0], 8'h00};
        end
        S_WR3: begin
          r_ptr  <= r_ptr + PTR_ONE;
          r_wbuf <= {r_wbuf[23:0], 8'h00};
          r_rem  <= r_rem - REM_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_ptr[ADDR_W-1:0];
  assign bus.mem_wdata = r_wbuf[31:24];
  assign busy          = r_busy;
  assign cpu_hold      = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Drives directed and random
//            loads, captures every byte write into a shadow memory and
//            compares it to the expected big-endian image of the source words.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MEM_BYTES = 1024;
  localparam int CNT_W     = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Source words and stall lengths for the load being driven.
  logic [31:0] words  [0:15];
  int          stalls [0:15];

  // Shadow memory: data plus the id of the load that last wrote each byte.
  logic [7:0] tb_mem [0:MEM_BYTES-1];
  int         tb_tag [0:MEM_BYTES-1];
  int         load_id = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         cyc_cnt = 0;
  int         we_lat = -1;
  int         done_lat = -1;
  bit         we_seen = 1'b0;

  always @(posedge CLK) begin
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      tb_tag[bus.mem_addr] <= load_id;
      wr_cnt <= wr_cnt + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (start && !busy && !RESET) begin
      cyc_cnt  <= 0;
      we_seen  <= 1'b0;
      we_lat   <= -1;
      done_lat <= -1;
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      if (bus.mem_we === 1'b1 && !we_seen) begin
        we_seen <= 1'b1;
        we_lat  <= cyc_cnt + 1;
      end
      if (done === 1'b1) done_lat <= cyc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every byte written by the current load must be exactly the expected
  // range, and each byte must be the matching big-endian slice of its word.
  task automatic check_mem(input string name, input int abase, input int nbytes);
    int bad;
    int off;
    bit ew;
    bit gw;
    logic [7:0] eb;
    bad = 0;
    for (int a = 0; a < MEM_BYTES; a++) begin
      ew = (a >= abase) && (a < abase + nbytes);
      gw = (tb_tag[a] == load_id);
      if (ew != gw) begin
        bad++;
      end else if (ew) begin
        off = a - abase;
        eb  = 8'(words[off / 4] >> (24 - 8 * (off % 4)));
        if (tb_mem[a] !== eb) bad++;
      end
    end
    chk({name, "_mem_bad_bytes"}, 64'(bad), 64'd0);
  endtask

  task automatic run_load(input string name, input int base, input int cnt, input bit chk_stall);
    int  abase, room, n_acc, k, miss, wr0, done0;
    bit  exp_err;
    abase   = base & ~3;
    room    = (MEM_BYTES - abase) / 4;
    n_acc   = (cnt < room) ? cnt : room;
    exp_err = (cnt > room);
    load_id++;
    wr0   = wr_cnt;
    done0 = done_cnt;

    start        = 1'b1;
    base_addr    = ADDR_W'(base);
    word_count   = CNT_W'(cnt);
    bus.in_valid = (stalls[0] == 0);
    bus.in_data  = words[0];
    @(negedge CLK);
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = CNT_W'($urandom);
    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
    chk({name, "_hold_after_start"}, 64'(cpu_hold), 64'd1);

    for (int i = 0; i < n_acc; i++) begin
      if (stalls[i] > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        for (int j = 1; j <= stalls[i]; j++) begin
          @(negedge CLK);
          if (chk_stall && j >= 4) begin
            chk({name, "_stall_we"}, 64'(bus.mem_we), 64'd0);
            chk({name, "_stall_ready"}, 64'(bus.in_ready), 64'd1);
          end
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 40) begin
        @(negedge CLK);
        k++;
      end
      chk({name, "_handshake_in_time"}, 64'(k < 40), 64'd1);
      @(negedge CLK);
      // Scramble the source after the handshake; written bytes must not care.
      bus.in_data = $urandom;
    end

    if (exp_err) begin
      bus.in_valid = 1'b1;
      miss = 0;
      for (int j = 0; j < 8; j++) begin
        if (bus.in_ready === 1'b1) miss++;
        @(negedge CLK);
      end
      chk({name, "_overflow_ready_seen"}, 64'(miss), 64'd0);
    end
    bus.in_valid = 1'b0;

    k = 0;
    while (busy !== 1'b0 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_idle_in_time"}, 64'(k < 60), 64'd1);
    chk({name, "_hold_idle"}, 64'(cpu_hold), 64'd0);
    chk({name, "_done_pulses"}, 64'(done_cnt - done0), exp_err ? 64'd0 : 64'd1);
    chk({name, "_error"}, 64'(error), 64'(exp_err));
    chk({name, "_write_count"}, 64'(wr_cnt - wr0), 64'(4 * n_acc));
    check_mem(name, abase, 4 * n_acc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int k;
    int wr0;

    RESET        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    word_count   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Two words from address 0 with a continuous source.
    words[0] = 32'h0801_1000; words[1] = 32'h0064_2800;
    stalls[0] = 0; stalls[1] = 0;
    run_load("t1", 0, 2, 1'b0);
    chk("t1_first_we_latency", 64'(we_lat), 64'd2);

    // Unaligned base is forced down to a word boundary.
    words[0] = 32'hDEAD_BEEF; stalls[0] = 0;
    run_load("t2", 32'h013, 1, 1'b0);

    // Seven-cycle source stalls between words.
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    stalls[0] = 0; stalls[1] = 7; stalls[2] = 7;
    run_load("t3", $urandom_range(0, 200), 3, 1'b1);

    // Second word would run past the end of memory.
    words[0] = $urandom; words[1] = $urandom;
    stalls[0] = 0; stalls[1] = 0;
    run_load("t4", MEM_BYTES - 4, 2, 1'b0);

    // Empty load: done on the next cycle, error cleared by the start.
    stalls[0] = 0;
    run_load("t5", $urandom_range(0, MEM_BYTES - 1), 0, 1'b0);
    chk("t5_done_latency", 64'(done_lat), 64'd1);

    // Random loads, some near the top of memory.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        words[i]  = $urandom;
        stalls[i] = $urandom_range(0, 3);
      end
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(MEM_BYTES - 24, MEM_BYTES - 1)
                                      : $urandom_range(0, MEM_BYTES - 1);
      run_load($sformatf("rnd%0d", r), b, $urandom_range(0, 6), 1'b1);
    end

    // Reset while the third byte is on the write port.
    load_id++;
    words[0] = $urandom;
    b   = $urandom_range(0, 255) * 4;
    wr0 = wr_cnt;
    start        = 1'b1;
    base_addr    = ADDR_W'(b);
    word_count   = CNT_W'(1);
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    @(negedge CLK);
    start = 1'b0;
    k = 0;
    while (bus.mem_we !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("t7_first_write_in_time", 64'(k < 20), 64'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("t7_wr2_we", 64'(bus.mem_we), 64'd1);
    chk("t7_wr2_addr", 64'(bus.mem_addr), 64'(b + 2));
    RESET = 1'b1;
    #1;
    chk("t7_rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("t7_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("t7_rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("t7_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("t7_rst_done", 64'(done), 64'd0);
    chk("t7_rst_error", 64'(error), 64'd0);
    @(negedge CLK);
    RESET        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("t7_write_count", 64'(wr_cnt - wr0), 64'd2);
    check_mem("t7", b, 2);

    // Normal operation resumes after the mid-load reset.
    for (int i = 0; i < 4; i++) begin
      words[i]  = $urandom;
      stalls[i] = $urandom_range(0, 2);
    end
    run_load("t8", $urandom_range(0, 500), 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
